uart_cmd_rx: RTL and testbench

//  Parametrised UART receiver and drive-command decoder for the robot board.

---
 rtl/uart_cmd_pkg.sv | 35 +++
 rtl/uart_rx_core.sv | 121 ++++++++++++
 rtl/uart_cmd_rx.sv | 104 ++++++++++
 tb/tb_uart_cmd_rx.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_cmd_pkg.sv
// Shared constants for the UART drive-command receiver: FSM encodings,
// command codes, LED patterns and duty levels.
package uart_cmd_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_START = 3'd1;
  localparam state_t ST_DATA  = 3'd2;
  localparam state_t ST_STOP  = 3'd3;
  localparam state_t ST_BREAK = 3'd4;

  // Clearing bit 5 folds ASCII lower case onto upper case.
  localparam logic [7:0] CASE_FOLD = 8'hDF;
  localparam logic [7:0] CMD_W     = 8'h57;
  localparam logic [7:0] CMD_A     = 8'h41;
  localparam logic [7:0] CMD_S     = 8'h53;
  localparam logic [7:0] CMD_D     = 8'h44;

  localparam logic [3:0] LED_W = 4'b1000;
  localparam logic [3:0] LED_A = 4'b0100;
  localparam logic [3:0] LED_S = 4'b0010;
  localparam logic [3:0] LED_D = 4'b0001;

  localparam int DUTY_FWD  = 100;
  localparam int DUTY_SLOW = 10;

  // Clamp a duty level to what a w-bit output can carry.
  function automatic int sat_duty(input int v, input int w);
    int mx;
    mx = (w >= 31) ? 32'h7FFF_FFFF : ((1 << w) - 1);
    return (v > mx) ? mx : v;
  endfunction

endpackage

// File: rtl/uart_rx_core.sv
// 8N1 oversampling UART receiver: rx synchroniser, tick divider and framing FSM.
// Emits each good byte as a one-cycle strobe, bad stop bits as frame_err.
module uart_rx_core
  import uart_cmd_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int BAUD       = 19200,
  parameter int OVERSAMPLE = 16
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_rx,
  output logic       o_valid,
  output logic [7:0] o_byte,
  output logic       o_frame_err,
  output logic       o_busy
);

  localparam int DIV   = (CLK_HZ + (BAUD * OVERSAMPLE) / 2) / (BAUD * OVERSAMPLE);
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int CNT_W = $clog2(OVERSAMPLE);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);

  logic [1:0]       r_sync;
  state_t           r_state;
  logic [DIV_W-1:0] r_div;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_idx;
  logic [7:0]       r_shift;
  logic [7:0]       r_byte;
  logic             r_valid;
  logic             r_ferr;

  logic w_rx;
  logic w_tick;

  assign w_rx   = r_sync[1];
  assign w_tick = (r_div == DIV_LAST);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync  <= 2'b11;
      r_state <= ST_IDLE;
      r_div   <= '0;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_byte  <= '0;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      r_sync  <= {r_sync[0], i_rx};
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
      r_div   <= w_tick ? '0 : r_div + 1'b1;
      case (r_state)
        ST_IDLE: begin
          // Restart the divider so the start-bit midpoint lands OVERSAMPLE/2 ticks out.
          if (!w_rx) begin
            r_state <= ST_START;
            r_cnt   <= '0;
            r_div   <= '0;
          end
        end
        ST_START: begin
          if (w_tick) begin
            if (r_cnt == CNT_HALF) begin
              r_cnt   <= '0;
              r_idx   <= '0;
              r_state <= w_rx ? ST_IDLE : ST_DATA;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        ST_DATA: begin
          if (w_tick) begin
            if (r_cnt == CNT_LAST) begin
              r_cnt          <= '0;
              r_shift[r_idx] <= w_rx;
              r_idx          <= r_idx + 1'b1;
              if (r_idx == 3'd7) r_state <= ST_STOP;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        ST_STOP: begin
          if (w_tick) begin
            if (r_cnt == CNT_LAST) begin
              r_cnt <= '0;
              if (w_rx) begin
                r_byte  <= r_shift;
                r_valid <= 1'b1;
                r_state <= ST_IDLE;
              end else begin
                r_ferr  <= 1'b1;
                r_state <= ST_BREAK;
              end
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        ST_BREAK: begin
          if (w_rx) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_valid     = r_valid;
  assign o_byte      = r_byte;
  assign o_frame_err = r_ferr;
  assign o_busy      = (r_state != ST_IDLE);

endmodule

// File: rtl/uart_cmd_rx.sv
// UART drive-command receiver: decodes W/A/S/D into LED and motor duty words,
// with a watchdog that forces a stop when commands dry up.
module uart_cmd_rx
  import uart_cmd_pkg::*;
#(
  parameter int CLK_HZ      = 50_000_000,
  parameter int BAUD        = 19200,
  parameter int OVERSAMPLE  = 16,
  parameter int DUTY_W      = 8,
  parameter int TIMEOUT_CYC = 50_000_000
) (
  input  logic              clk_50M,
  input  logic              rst,
  input  logic              rx,
  output logic              cmd_valid,
  output logic [7:0]        cmd_byte,
  output logic              frame_err,
  output logic              rx_busy,
  output logic [3:0]        led,
  output logic [DUTY_W-1:0] duty_l,
  output logic [DUTY_W-1:0] duty_r,
  output logic              timeout
);

  localparam logic [DUTY_W-1:0] D_FWD  = DUTY_W'(sat_duty(DUTY_FWD, DUTY_W));
  localparam logic [DUTY_W-1:0] D_SLOW = DUTY_W'(sat_duty(DUTY_SLOW, DUTY_W));

  localparam int WD_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

  uart_rx_core #(
    .CLK_HZ    (CLK_HZ),
    .BAUD      (BAUD),
    .OVERSAMPLE(OVERSAMPLE)
  ) u_core (
    .i_clk      (clk_50M),
    .i_rst      (rst),
    .i_rx       (rx),
    .o_valid    (cmd_valid),
    .o_byte     (cmd_byte),
    .o_frame_err(frame_err),
    .o_busy     (rx_busy)
  );

  logic [7:0]        w_key;
  logic              w_hit;
  logic [3:0]        w_led;
  logic [DUTY_W-1:0] w_dl;
  logic [DUTY_W-1:0] w_dr;

  assign w_key = cmd_byte & CASE_FOLD;

  always_comb begin
    w_hit = cmd_valid;
    w_led = LED_S;
    w_dl  = '0;
    w_dr  = '0;
    case (w_key)
      CMD_W: begin w_led = LED_W; w_dl = D_FWD;  w_dr = D_FWD;  end
      CMD_A: begin w_led = LED_A; w_dl = D_SLOW; w_dr = D_FWD;  end
      CMD_S: begin w_led = LED_S; w_dl = '0;     w_dr = '0;     end
      CMD_D: begin w_led = LED_D; w_dl = D_FWD;  w_dr = D_SLOW; end
      default: w_hit = 1'b0;
    endcase
  end

  logic [3:0]        r_led;
  logic [DUTY_W-1:0] r_dl;
  logic [DUTY_W-1:0] r_dr;
  logic              r_tmo;
  logic [WD_W-1:0]   r_wd;

  // A recognised command outranks watchdog expiry in the same cycle.
  always_ff @(posedge clk_50M or posedge rst) begin
    if (rst) begin
      r_led <= '0;
      r_dl  <= '0;
      r_dr  <= '0;
      r_tmo <= 1'b0;
      r_wd  <= '0;
    end else if (w_hit) begin
      r_led <= w_led;
      r_dl  <= w_dl;
      r_dr  <= w_dr;
      r_tmo <= 1'b0;
      r_wd  <= '0;
    end else if ((TIMEOUT_CYC != 0) && !r_tmo) begin
      if (r_wd == WD_LAST) begin
        r_tmo <= 1'b1;
        r_led <= LED_S;
        r_dl  <= '0;
        r_dr  <= '0;
      end else begin
        r_wd <= r_wd + 1'b1;
      end
    end
  end

  assign led     = r_led;
  assign duty_l  = r_dl;
  assign duty_r  = r_dr;
  assign timeout = r_tmo;

endmodule

// File: tb/tb_uart_cmd_rx.sv
// Randomised and directed bench for uart_cmd_rx against a byte-level command model.
module tb_uart_cmd_rx;

  localparam int CLK_HZ = 800_000;
  localparam int BAUD   = 10_000;
  localparam int OS     = 16;
  localparam int DW     = 8;
  localparam int TO     = 10_000;
  localparam int DIV    = 5;
  localparam int BIT    = DIV * OS;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rx  = 1'b1;
  logic          cmd_valid;
  logic [7:0]    cmd_byte;
  logic          frame_err;
  logic          rx_busy;
  logic [3:0]    led;
  logic [DW-1:0] duty_l;
  logic [DW-1:0] duty_r;
  logic          timeout;

  uart_cmd_rx #(
    .CLK_HZ(CLK_HZ), .BAUD(BAUD), .OVERSAMPLE(OS), .DUTY_W(DW), .TIMEOUT_CYC(TO)
  ) dut (
    .clk_50M(clk), .rst(rst), .rx(rx),
    .cmd_valid(cmd_valid), .cmd_byte(cmd_byte), .frame_err(frame_err), .rx_busy(rx_busy),
    .led(led), .duty_l(duty_l), .duty_r(duty_r), .timeout(timeout)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // Reference model: expected bytes in flight plus the command state they imply.
  logic [7:0] exp_q[$];
  logic [3:0] m_led = '0;
  logic [7:0] m_dl  = '0;
  logic [7:0] m_dr  = '0;
  logic       m_tmo = 1'b0;
  int n_valid  = 0;
  int n_ferr   = 0;
  int busy_run = 0;
  int busy_max = 0;
  bit pend     = 0;

  task automatic m_apply(input logic [7:0] b);
    case (b)
      "W", "w": begin m_led = 4'b1000; m_dl = 100; m_dr = 100; m_tmo = 0; end
      "A", "a": begin m_led = 4'b0100; m_dl = 10;  m_dr = 100; m_tmo = 0; end
      "S", "s": begin m_led = 4'b0010; m_dl = 0;   m_dr = 0;   m_tmo = 0; end
      "D", "d": begin m_led = 4'b0001; m_dl = 100; m_dr = 10;  m_tmo = 0; end
      default: ;
    endcase
  endtask

  always @(negedge clk) begin
    logic [7:0] eb;
    if (pend) begin
      pend = 0;
      chk("dec_led", led, m_led);
      chk("dec_duty_l", duty_l, m_dl);
      chk("dec_duty_r", duty_r, m_dr);
      chk("dec_timeout", timeout, m_tmo);
    end
    if (rst || !rx_busy) busy_run = 0;
    else busy_run++;
    if (busy_run > busy_max) busy_max = busy_run;
    if (frame_err) n_ferr++;
    if (cmd_valid) begin
      n_valid++;
      chk("valid_expected", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        eb = exp_q.pop_front();
        chk("cmd_byte", cmd_byte, eb);
        m_apply(eb);
        pend = 1;
      end
    end
  end

  task automatic drive_bit(input logic v);
    rx = v;
    repeat (BIT) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b, input logic stopb);
    if (stopb) exp_q.push_back(b);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stopb);
    rx = 1'b1;
  endtask

  task automatic chk_all_zero(input string pfx);
    chk({pfx, "_cmd_valid"}, cmd_valid, 0);
    chk({pfx, "_cmd_byte"}, cmd_byte, 0);
    chk({pfx, "_frame_err"}, frame_err, 0);
    chk({pfx, "_rx_busy"}, rx_busy, 0);
    chk({pfx, "_led"}, led, 0);
    chk({pfx, "_duty_l"}, duty_l, 0);
    chk({pfx, "_duty_r"}, duty_r, 0);
    chk({pfx, "_timeout"}, timeout, 0);
  endtask

  initial begin
    int v0, f0;
    logic [7:0] wb;
    logic [7:0] keys[8];
    logic [7:0] b;
    keys = '{"W", "A", "S", "D", "w", "a", "s", "d"};

    repeat (5) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;
    repeat (20) @(negedge clk);

    // 1: forward command
    v0 = n_valid;
    send("W", 1'b1);
    repeat (4) @(negedge clk);
    chk("t1_nvalid", n_valid - v0, 1);
    chk("t1_led", led, 4'b1000);
    chk("t1_duty_l", duty_l, 100);
    chk("t1_duty_r", duty_r, 100);
    repeat (BIT) @(negedge clk);

    // 2: lower-case fold, then an unknown byte leaves outputs alone
    send("a", 1'b1);
    repeat (4) @(negedge clk);
    chk("t2_led", led, 4'b0100);
    chk("t2_duty_l", duty_l, 10);
    v0 = n_valid;
    send("Z", 1'b1);
    repeat (4) @(negedge clk);
    chk("t2_z_nvalid", n_valid - v0, 1);
    chk("t2_z_cmd_byte", cmd_byte, 8'h5A);
    chk("t2_z_led", led, 4'b0100);
    chk("t2_z_duty_r", duty_r, 100);

    // 3: bad stop bit followed by a line break
    v0 = n_valid; f0 = n_ferr;
    send(8'h44, 1'b0);
    rx = 1'b0;
    repeat (3 * BIT) @(negedge clk);
    chk("t3_busy_in_break", rx_busy, 1);
    rx = 1'b1;
    repeat (10) @(negedge clk);
    chk("t3_busy_after", rx_busy, 0);
    chk("t3_nferr", n_ferr - f0, 1);
    chk("t3_nvalid", n_valid - v0, 0);
    chk("t3_cmd_byte_held", cmd_byte, 8'h5A);
    send("S", 1'b1);
    repeat (4) @(negedge clk);
    chk("t3_s_led", led, 4'b0010);

    // 4: short glitch is rejected
    repeat (BIT) @(negedge clk);
    v0 = n_valid; f0 = n_ferr; busy_max = 0;
    rx = 1'b0;
    repeat (OS / 4 * DIV) @(negedge clk);
    rx = 1'b1;
    repeat (2 * BIT) @(negedge clk);
    chk("t4_nvalid", n_valid - v0, 0);
    chk("t4_nferr", n_ferr - f0, 0);
    chk("t4_busy", rx_busy, 0);
    chk("t4_busy_le_bit", busy_max <= BIT, 1);
    chk("t4_busy_seen", busy_max > 0, 1);

    // 5: watchdog expiry and recovery
    send("W", 1'b1);
    repeat (TO - 300) @(negedge clk);
    chk("t5_timeout_early", timeout, 0);
    chk("t5_led_early", led, 4'b1000);
    repeat (400) @(negedge clk);
    chk("t5_timeout", timeout, 1);
    chk("t5_led", led, 4'b0010);
    chk("t5_duty_l", duty_l, 0);
    chk("t5_duty_r", duty_r, 0);
    m_led = 4'b0010; m_dl = 0; m_dr = 0; m_tmo = 1;
    send("D", 1'b1);
    repeat (4) @(negedge clk);
    chk("t5_d_timeout", timeout, 0);
    chk("t5_d_led", led, 4'b0001);
    chk("t5_d_duty_l", duty_l, 100);
    chk("t5_d_duty_r", duty_r, 10);

    // 6: reset in the middle of data bit 4
    repeat (BIT) @(negedge clk);
    v0 = n_valid;
    wb = "W";
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(wb[i]);
    rx = wb[4];
    repeat (BIT / 2) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk_all_zero("t6_rst");
    m_led = '0; m_dl = 0; m_dr = 0; m_tmo = 0;
    rx = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    repeat (2 * BIT) @(negedge clk);
    chk("t6_nvalid", n_valid - v0, 0);
    send("A", 1'b1);
    repeat (4) @(negedge clk);
    chk("t6_a_led", led, 4'b0100);
    chk("t6_a_duty_l", duty_l, 10);
    chk("t6_a_duty_r", duty_r, 100);

    // Random byte stream; every third byte is a command so the watchdog stays quiet.
    v0 = n_valid;
    for (int k = 0; k < 24; k++) begin
      if (k % 3 == 0) b = keys[$urandom_range(0, 7)];
      else b = 8'($urandom);
      send(b, 1'b1);
      repeat ($urandom_range(0, 100)) @(negedge clk);
    end
    repeat (BIT) @(negedge clk);
    chk("rand_nvalid", n_valid - v0, 24);
    chk("rand_q_empty", exp_q.size(), 0);
    chk("rand_timeout", timeout, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
